// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit pipelined processor: instruction fields,
// opcode classes, operand-mux select codes and the hazard-pipeline entry.
package cpu_pkg;

  localparam int INS_W  = 20;
  localparam int DATA_W = 8;

  localparam int OP_HI = 19;
  localparam int OP_LO = 15;
  localparam int RW_HI = 14;
  localparam int RW_LO = 10;
  localparam int RA_HI = 9;
  localparam int RA_LO = 5;
  localparam int RB_HI = 4;
  localparam int RB_LO = 0;

  localparam logic [4:0] OP_NOP    = 5'b00000;
  localparam logic [4:0] OP_ALU_LO = 5'b00001;
  localparam logic [4:0] OP_ALU_HI = 5'b01111;
  localparam logic [4:0] OP_IMM_LO = 5'b10000;
  localparam logic [4:0] OP_IMM_HI = 5'b10111;
  localparam logic [4:0] OP_LOAD   = 5'b11000;
  localparam logic [4:0] OP_STORE  = 5'b11001;

  localparam logic [1:0] SEL_RF = 2'b00;
  localparam logic [1:0] SEL_EX = 2'b01;
  localparam logic [1:0] SEL_DM = 2'b10;
  localparam logic [1:0] SEL_WB = 2'b11;

  typedef struct packed {
    logic [4:0] rw;
    logic       we;
    logic       is_load;
  } pipe_entry_t;

  localparam int PIPE_ENTRY_W = $bits(pipe_entry_t);
  localparam pipe_entry_t PIPE_BUBBLE = '0;

  // Nearest in-flight producer of src wins; entries that do not write never match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input pipe_entry_t e1,
                                         input pipe_entry_t e2,
                                         input pipe_entry_t e3);
    if (e1.we && e1.rw == src)      return SEL_EX;
    else if (e2.we && e2.rw == src) return SEL_DM;
    else if (e3.we && e3.rw == src) return SEL_WB;
    else                            return SEL_RF;
  endfunction

endpackage

// File: rtl/ins_decode.sv
// Combinational instruction decoder: splits the fields and classifies the
// opcode into write/load/operand-usage/immediate attributes.
module ins_decode
  import cpu_pkg::*;
(
  input  logic [INS_W-1:0]  ins,
  output logic [4:0]        op,
  output logic [4:0]        rw,
  output logic [4:0]        ra,
  output logic [4:0]        rb,
  output logic              we,
  output logic              is_load,
  output logic              uses_ra,
  output logic              uses_rb,
  output logic              imm_sel,
  output logic [DATA_W-1:0] imm
);

  assign op = ins[OP_HI:OP_LO];
  assign rw = ins[RW_HI:RW_LO];
  assign ra = ins[RA_HI:RA_LO];
  assign rb = ins[RB_HI:RB_LO];

  always_comb begin
    we      = 1'b0;
    is_load = 1'b0;
    uses_ra = 1'b0;
    uses_rb = 1'b0;
    imm_sel = 1'b0;
    if (op >= OP_ALU_LO && op <= OP_ALU_HI) begin
      we      = 1'b1;
      uses_ra = 1'b1;
      uses_rb = 1'b1;
    end else if (op >= OP_IMM_LO && op <= OP_IMM_HI) begin
      we      = 1'b1;
      uses_ra = 1'b1;
      imm_sel = 1'b1;
    end else if (op == OP_LOAD) begin
      we      = 1'b1;
      is_load = 1'b1;
      uses_ra = 1'b1;
      imm_sel = 1'b1;
    end else if (op == OP_STORE) begin
      uses_ra = 1'b1;
      uses_rb = 1'b1;
    end
  end

  // The RB field doubles as the 5-bit immediate for ALU-imm and LOAD.
  assign imm = imm_sel ? {3'b000, rb} : '0;

endmodule

// File: rtl/fwd_ctrl.sv
// Operand-forwarding and load-use hazard controller. Tracks the destinations
// of the EX/DM/WB instructions and drives the register bank's operand muxes.
module fwd_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] ins,
  output logic        stall,
  output logic [1:0]  mux_sel_A,
  output logic [1:0]  mux_sel_B,
  output logic        imm_sel,
  output logic [7:0]  imm,
  output logic [4:0]  op_ex,
  output logic [4:0]  RW_dm,
  output logic        we_dm
);

  logic [4:0]        d_op, d_rw, d_ra, d_rb;
  logic              d_we, d_is_load, d_uses_ra, d_uses_rb, d_imm_sel;
  logic [DATA_W-1:0] d_imm;

  pipe_entry_t p1, p2, p3;
  pipe_entry_t d_entry;
  logic [1:0]  sel_a_nxt, sel_b_nxt;

  ins_decode u_dec (
    .ins     (ins),
    .op      (d_op),
    .rw      (d_rw),
    .ra      (d_ra),
    .rb      (d_rb),
    .we      (d_we),
    .is_load (d_is_load),
    .uses_ra (d_uses_ra),
    .uses_rb (d_uses_rb),
    .imm_sel (d_imm_sel),
    .imm     (d_imm)
  );

  // A load in p1 has no data until DM, so a direct consumer must wait one cycle.
  assign stall = p1.is_load && p1.we &&
                 ((d_uses_ra && d_ra == p1.rw) || (d_uses_rb && d_rb == p1.rw));

  always_comb begin
    d_entry         = PIPE_BUBBLE;
    d_entry.rw      = d_rw;
    d_entry.we      = d_we;
    d_entry.is_load = d_is_load;
    sel_a_nxt       = d_uses_ra ? fwd_sel(d_ra, p1, p2, p3) : SEL_RF;
    sel_b_nxt       = d_uses_rb ? fwd_sel(d_rb, p1, p2, p3) : SEL_RF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p1        <= PIPE_BUBBLE;
      p2        <= PIPE_BUBBLE;
      p3        <= PIPE_BUBBLE;
      mux_sel_A <= SEL_RF;
      mux_sel_B <= SEL_RF;
      imm_sel   <= 1'b0;
      imm       <= '0;
      op_ex     <= OP_NOP;
    end else if (stall) begin
      p1        <= PIPE_BUBBLE;
      p2        <= p1;
      p3        <= p2;
      mux_sel_A <= SEL_RF;
      mux_sel_B <= SEL_RF;
      imm_sel   <= 1'b0;
      imm       <= '0;
      op_ex     <= OP_NOP;
    end else begin
      p1        <= d_entry;
      p2        <= p1;
      p3        <= p2;
      mux_sel_A <= sel_a_nxt;
      mux_sel_B <= sel_b_nxt;
      imm_sel   <= d_imm_sel;
      imm       <= d_imm;
      op_ex     <= d_op;
    end
  end

  assign RW_dm = p2.rw;
  assign we_dm = p2.we;

endmodule
